// File: rtl/conv_seq.sv
// conv_seq: sequencer for the 5x5 convolution unit.
// Loads the five weight rows once per layer, then walks every valid 5x5
// window of the IMG_H x IMG_W pixel map in raster order. For each window it
// fetches five row words, issues them to the conv unit, waits for the result
// and writes it to the output RAM. Exactly one window is in flight at a time.
module conv_seq #(
  parameter int DW       = 9,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int ADDR_W   = 10,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [DW-1:0]       bias_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wt_rd_en,
  output logic [2:0]          wt_addr,
  input  logic [5*DW-1:0]     wt_data,
  output logic                px_rd_en,
  output logic [ADDR_W-1:0]   px_addr,
  input  logic [5*DW-1:0]     px_data,
  output logic [5*DW-1:0]     x_m_1,
  output logic [5*DW-1:0]     x_m_2,
  output logic [5*DW-1:0]     x_m_3,
  output logic [5*DW-1:0]     x_m_4,
  output logic [5*DW-1:0]     x_m_5,
  output logic [5*DW-1:0]     weight_m_1,
  output logic [5*DW-1:0]     weight_m_2,
  output logic [5*DW-1:0]     weight_m_3,
  output logic [5*DW-1:0]     weight_m_4,
  output logic [5*DW-1:0]     weight_m_5,
  output logic [DW-1:0]       bias,
  output logic                x_valid,
  input  logic                conv_valid,
  input  logic [DW-1:0]       conv_data,
  output logic                out_we,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DW-1:0]       out_data
);

  // Wait counter holds values 0..WAIT_MAX with headroom for the compare.
  localparam int WCW = $clog2(WAIT_MAX + 1) + 1;
  localparam logic [WCW-1:0]    WAIT_LIM = WCW'(WAIT_MAX);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(IMG_W - 4);
  localparam logic [ADDR_W-1:0] R_LAST   = ADDR_W'(IMG_H - 5);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(IMG_W - 5);

  // Reject geometries the address arithmetic cannot represent.
  if (IMG_W < 5 || IMG_H < 5) begin : g_bad_dims
    $error("conv_seq: image must be at least 5x5");
  end
  if (IMG_H * IMG_W > (2 ** ADDR_W)) begin : g_bad_addr
    $error("conv_seq: IMG_H*IMG_W does not fit in ADDR_W bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        k;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] c;
  logic [WCW-1:0]    wait_cnt;

  logic [2:0]        k_inc;
  logic [ADDR_W-1:0] r_nxt;
  logic [ADDR_W-1:0] c_nxt;
  logic              last_win;

  // Word address of the 5-pixel group starting at (row, col).
  function automatic logic [ADDR_W-1:0] px_word_addr(input logic [ADDR_W-1:0] row,
                                                     input logic [ADDR_W-1:0] col);
    return row * IMG_W_A + col;
  endfunction

  // Raster address of the result for the window anchored at (row, col).
  function automatic logic [ADDR_W-1:0] out_word_addr(input logic [ADDR_W-1:0] row,
                                                      input logic [ADDR_W-1:0] col);
    return row * OUT_W_A + col;
  endfunction

  // Next window position in raster order and end-of-layer detection.
  always_comb begin
    k_inc    = k + 3'd1;
    last_win = (r == R_LAST) && (c == C_LAST);
    r_nxt    = r;
    c_nxt    = c + ADDR_W'(1);
    if (c == C_LAST) begin
      c_nxt = '0;
      r_nxt = r + ADDR_W'(1);
    end
  end

  // Layer sequencer: all control and operand registers, abort acts like a synchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      k          <= '0;
      r          <= '0;
      c          <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wt_rd_en   <= 1'b0;
      wt_addr    <= '0;
      px_rd_en   <= 1'b0;
      px_addr    <= '0;
      x_m_1      <= '0;
      x_m_2      <= '0;
      x_m_3      <= '0;
      x_m_4      <= '0;
      x_m_5      <= '0;
      weight_m_1 <= '0;
      weight_m_2 <= '0;
      weight_m_3 <= '0;
      weight_m_4 <= '0;
      weight_m_5 <= '0;
      bias       <= '0;
      x_valid    <= 1'b0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      k          <= '0;
      r          <= '0;
      c          <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wt_rd_en   <= 1'b0;
      wt_addr    <= '0;
      px_rd_en   <= 1'b0;
      px_addr    <= '0;
      x_m_1      <= '0;
      x_m_2      <= '0;
      x_m_3      <= '0;
      x_m_4      <= '0;
      x_m_5      <= '0;
      weight_m_1 <= '0;
      weight_m_2 <= '0;
      weight_m_3 <= '0;
      weight_m_4 <= '0;
      weight_m_5 <= '0;
      bias       <= '0;
      x_valid    <= 1'b0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        // Idle: accept a layer start, latch the bias, issue weight row 0 read.
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            state    <= S_LOAD_W;
            busy     <= 1'b1;
            bias     <= bias_in;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            wt_rd_en <= 1'b1;
            wt_addr  <= '0;
          end
        end

        // Weight load: reads at k=0..4, RAM data lands one cycle later at k=1..5.
        S_LOAD_W: begin
          case (k)
            3'd1:    weight_m_1 <= wt_data;
            3'd2:    weight_m_2 <= wt_data;
            3'd3:    weight_m_3 <= wt_data;
            3'd4:    weight_m_4 <= wt_data;
            3'd5:    weight_m_5 <= wt_data;
            default: ;
          endcase
          if (k < 3'd4) begin
            wt_addr <= k_inc;
          end else begin
            wt_rd_en <= 1'b0;
            wt_addr  <= '0;
          end
          if (k == 3'd5) begin
            state    <= S_FETCH;
            k        <= '0;
            px_rd_en <= 1'b1;
            px_addr  <= px_word_addr(r, c);
          end else begin
            k <= k_inc;
          end
        end

        // Window fetch: row words r..r+4 at column c, same one-cycle read latency.
        S_FETCH: begin
          case (k)
            3'd1:    x_m_1 <= px_data;
            3'd2:    x_m_2 <= px_data;
            3'd3:    x_m_3 <= px_data;
            3'd4:    x_m_4 <= px_data;
            3'd5:    x_m_5 <= px_data;
            default: ;
          endcase
          if (k < 3'd4) begin
            px_addr <= px_word_addr(r + ADDR_W'(k_inc), c);
          end else begin
            px_rd_en <= 1'b0;
            px_addr  <= '0;
          end
          if (k == 3'd5) begin
            state   <= S_ISSUE;
            k       <= '0;
            x_valid <= 1'b1;
          end else begin
            k <= k_inc;
          end
        end

        // Issue: x_valid is high for this single cycle; operands stay put.
        S_ISSUE: begin
          x_valid  <= 1'b0;
          state    <= S_WAIT;
          wait_cnt <= WCW'(1);
        end

        // Wait: wait_cnt numbers the current WAIT cycle; a result in the last one still wins.
        S_WAIT: begin
          if (conv_valid) begin
            out_data <= conv_data;
            out_we   <= 1'b1;
            out_addr <= out_word_addr(r, c);
            state    <= S_WRITE;
          end else if (wait_cnt >= WAIT_LIM) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
            wait_cnt <= '0;
            r        <= '0;
            c        <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        // Write: out_we is high this cycle; advance to the next window or finish.
        S_WRITE: begin
          out_we   <= 1'b0;
          wait_cnt <= '0;
          if (last_win) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            r     <= '0;
            c     <= '0;
          end else begin
            r        <= r_nxt;
            c        <= c_nxt;
            state    <= S_FETCH;
            k        <= '0;
            px_rd_en <= 1'b1;
            px_addr  <= px_word_addr(r_nxt, c_nxt);
          end
        end

        // Done: done pulse is visible for this one cycle.
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq.sv
// Testbench for conv_seq: pixel/weight RAM models, a conv responder with
// random latency, and a reference built from window geometry (raster window
// index -> row/col -> expected addresses, operands and result slot).
module tb_conv_seq;

  localparam int DW       = 9;
  localparam int IMG_W    = 6;
  localparam int IMG_H    = 6;
  localparam int ADDR_W   = 10;
  localparam int WAIT_MAX = 8;
  localparam int RW       = 5 * DW;
  localparam int OW       = IMG_W - 4;
  localparam int N        = OW * (IMG_H - 4);

  logic              clk;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [DW-1:0]     bias_in;
  logic              busy;
  logic              done;
  logic              err;
  logic              wt_rd_en;
  logic [2:0]        wt_addr;
  logic [RW-1:0]     wt_data;
  logic              px_rd_en;
  logic [ADDR_W-1:0] px_addr;
  logic [RW-1:0]     px_data;
  logic [RW-1:0]     x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
  logic [RW-1:0]     weight_m_1, weight_m_2, weight_m_3, weight_m_4, weight_m_5;
  logic [DW-1:0]     bias;
  logic              x_valid;
  logic              conv_valid;
  logic [DW-1:0]     conv_data;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DW-1:0]     out_data;

  conv_seq #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bias_in(bias_in),
    .busy(busy), .done(done), .err(err),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .px_rd_en(px_rd_en), .px_addr(px_addr), .px_data(px_data),
    .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4), .x_m_5(x_m_5),
    .weight_m_1(weight_m_1), .weight_m_2(weight_m_2), .weight_m_3(weight_m_3),
    .weight_m_4(weight_m_4), .weight_m_5(weight_m_5),
    .bias(bias), .x_valid(x_valid), .conv_valid(conv_valid), .conv_data(conv_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] wt_mem [5];
  logic [RW-1:0] px_mem [IMG_W*IMG_H];

  // Synchronous-read RAM models: data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (wt_rd_en && wt_addr < 3'd5) wt_data <= wt_mem[wt_addr];
    if (px_rd_en && int'(px_addr) < IMG_W*IMG_H) px_data <= px_mem[px_addr];
  end

  int checks = 0;
  int errors = 0;

  int cyc, win, pend_cnt, lat_sum, n_we, busy_cyc, xv_cyc, err_cyc, done_cyc;
  bit pend, got_done, got_err, respond, spur;
  logic [DW-1:0] bias_exp;
  logic [DW-1:0] res_q [$];
  int px_seen [$];
  int wt_seen [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[RW-1:0];
  endfunction

  function automatic logic [63:0] px_at(input int row, input int col);
    return 64'(px_mem[row*IMG_W + col]);
  endfunction

  // One clock of observation at the falling edge plus the conv responder.
  task automatic cycle_mon();
    int r, c, lat;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (busy) busy_cyc++;
    conv_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend       = 1'b0;
        d          = DW'($urandom);
        conv_valid = 1'b1;
        conv_data  = d;
        res_q.push_back(d);
      end
    end else if (spur && !x_valid && px_rd_en) begin
      conv_valid = 1'b1;
      conv_data  = DW'($urandom);
    end
    if (wt_rd_en) wt_seen.push_back(int'(wt_addr));
    if (px_rd_en) px_seen.push_back(int'(px_addr));
    if (x_valid) begin
      xv_cyc = cyc;
      r = win / OW;
      c = win % OW;
      chk("x_m_1", 64'(x_m_1), px_at(r + 0, c));
      chk("x_m_2", 64'(x_m_2), px_at(r + 1, c));
      chk("x_m_3", 64'(x_m_3), px_at(r + 2, c));
      chk("x_m_4", 64'(x_m_4), px_at(r + 3, c));
      chk("x_m_5", 64'(x_m_5), px_at(r + 4, c));
      chk("weight_m_1", 64'(weight_m_1), 64'(wt_mem[0]));
      chk("weight_m_2", 64'(weight_m_2), 64'(wt_mem[1]));
      chk("weight_m_3", 64'(weight_m_3), 64'(wt_mem[2]));
      chk("weight_m_4", 64'(weight_m_4), 64'(wt_mem[3]));
      chk("weight_m_5", 64'(weight_m_5), 64'(wt_mem[4]));
      chk("bias", 64'(bias), 64'(bias_exp));
      chk("px_reads", 64'(px_seen.size()), 64'd5);
      foreach (px_seen[i]) chk("px_addr", 64'(px_seen[i]), 64'((r + i) * IMG_W + c));
      px_seen.delete();
      win++;
      if (respond) begin
        if (win == 1) lat = 7;
        else if (win == 2) lat = WAIT_MAX;
        else lat = int'($urandom_range(1, WAIT_MAX));
        pend     = 1'b1;
        pend_cnt = lat;
        lat_sum += lat;
      end
    end
    if (out_we) begin
      chk("result_available", 64'(res_q.size() > 0), 64'd1);
      chk("out_addr", 64'(out_addr), 64'(n_we));
      if (res_q.size() > 0) chk("out_data", 64'(out_data), 64'(res_q.pop_front()));
      n_we++;
    end
    if (done) begin got_done = 1'b1; done_cyc = cyc; end
    if (err)  begin got_err = 1'b1;  err_cyc = cyc;  end
  endtask

  task automatic clear_state(input bit resp, input bit sp);
    cyc = 0; win = 0; pend = 1'b0; pend_cnt = 0; lat_sum = 0; n_we = 0;
    busy_cyc = 0; xv_cyc = 0; err_cyc = 0; done_cyc = 0;
    got_done = 1'b0; got_err = 1'b0; respond = resp; spur = sp;
    res_q.delete(); px_seen.delete(); wt_seen.delete();
  endtask

  // Start a layer (with a stray conv_valid in IDLE) and run to done/err.
  task automatic run_layer(input bit resp, input bit sp, input logic [DW-1:0] b);
    clear_state(resp, sp);
    bias_in    = b;
    bias_exp   = b;
    start      = 1'b1;
    conv_valid = 1'b1;
    conv_data  = DW'($urandom);
    cycle_mon();
    bias_in = ~b;
    while (!got_done && !got_err && cyc < 3000) cycle_mon();
    chk("layer_terminated", 64'(cyc < 3000), 64'd1);
  endtask

  task automatic check_layer_ok();
    chk("done_seen", 64'(got_done), 64'd1);
    chk("err_absent", 64'(got_err), 64'd0);
    chk("we_count", 64'(n_we), 64'(N));
    chk("window_count", 64'(win), 64'(N));
    chk("busy_cycles", 64'(busy_cyc), 64'(6 + N * 8 + lat_sum));
    chk("done_after_busy", 64'(done_cyc), 64'(busy_cyc + 1));
    chk("wt_reads", 64'(wt_seen.size()), 64'd5);
    foreach (wt_seen[i]) chk("wt_addr", 64'(wt_seen[i]), 64'(i));
    cycle_mon();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("weights_held_1", 64'(weight_m_1), 64'(wt_mem[0]));
    chk("weights_held_5", 64'(weight_m_5), 64'(wt_mem[4]));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; bias_in = '0;
    conv_valid = 1'b0; conv_data = '0;
    wt_mem[0] = RW'(16); wt_mem[1] = RW'(17); wt_mem[2] = RW'(18);
    wt_mem[3] = RW'(19); wt_mem[4] = RW'(11);
    for (int i = 0; i < IMG_W*IMG_H; i++) px_mem[i] = rnd_word();
    clear_state(1'b0, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wt_rd_en", 64'(wt_rd_en), 64'd0);
    chk("rst_px_rd_en", 64'(px_rd_en), 64'd0);
    chk("rst_x_valid", 64'(x_valid), 64'd0);
    chk("rst_out_we", 64'(out_we), 64'd0);
    chk("rst_x_m_3", 64'(x_m_3), 64'd0);
    rstn = 1'b1;

    // Full layer with fixed weights 16,17,18,19,11.
    run_layer(1'b1, 1'b0, 9'h0A5);
    check_layer_ok();

    // Asynchronous reset in the middle of a window fetch.
    clear_state(1'b1, 1'b0);
    bias_in = 9'h033; bias_exp = 9'h033; start = 1'b1;
    cycle_mon();
    for (int i = 0; i < 20 && !px_rd_en; i++) cycle_mon();
    chk("fetch_reached", 64'(px_rd_en), 64'd1);
    cycle_mon();
    rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_px_rd_en", 64'(px_rd_en), 64'd0);
    chk("arst_px_addr", 64'(px_addr), 64'd0);
    chk("arst_weight_m_1", 64'(weight_m_1), 64'd0);
    chk("arst_bias", 64'(bias), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Full layer after reset, random data, stray conv_valid pulses during fetch.
    for (int i = 0; i < 5; i++) wt_mem[i] = rnd_word();
    for (int i = 0; i < IMG_W*IMG_H; i++) px_mem[i] = rnd_word();
    run_layer(1'b1, 1'b1, DW'($urandom));
    check_layer_ok();

    // Timeout: conv never answers.
    run_layer(1'b0, 1'b0, DW'($urandom));
    chk("to_err_seen", 64'(got_err), 64'd1);
    chk("to_no_done", 64'(got_done), 64'd0);
    chk("to_no_we", 64'(n_we), 64'd0);
    chk("to_err_delay", 64'(err_cyc - xv_cyc), 64'(WAIT_MAX + 1));
    chk("to_busy_low", 64'(busy), 64'd0);
    cycle_mon();
    chk("to_err_one_cycle", 64'(err), 64'd0);

    // Start while busy is ignored; abort in WAIT returns to IDLE silently.
    clear_state(1'b0, 1'b0);
    bias_in = DW'($urandom); bias_exp = bias_in; start = 1'b1;
    cycle_mon();
    for (int i = 0; i < 20 && !px_rd_en; i++) cycle_mon();
    start = 1'b1;
    for (int i = 0; i < 20 && win == 0; i++) cycle_mon();
    chk("ab_issued", 64'(win), 64'd1);
    cycle_mon();
    abort = 1'b1;
    cycle_mon();
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_x_m_1", 64'(x_m_1), 64'd0);
    chk("ab_weight_m_2", 64'(weight_m_2), 64'd0);
    chk("ab_bias", 64'(bias), 64'd0);
    repeat (20) cycle_mon();
    chk("ab_no_done", 64'(got_done), 64'd0);
    chk("ab_no_err", 64'(got_err), 64'd0);
    chk("ab_stays_idle", 64'(busy), 64'd0);

    // abort and start together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1;
    cycle_mon();
    cycle_mon();
    chk("abst_busy", 64'(busy), 64'd0);
    chk("abst_wt_rd_en", 64'(wt_rd_en), 64'd0);

    // One more full layer with fresh data.
    for (int i = 0; i < 5; i++) wt_mem[i] = rnd_word();
    for (int i = 0; i < IMG_W*IMG_H; i++) px_mem[i] = rnd_word();
    run_layer(1'b1, 1'b1, DW'($urandom));
    check_layer_ok();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
